// File: rtl/bfp_pkg.sv
// Shared types and helpers for the block-floating-point normalizer.
package bfp_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Width of a redundant-sign-bit count for a WIDTH-bit component (0..WIDTH-1).
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic int unsigned min3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/bfp_blk_buf.sv
// Block sample store: one synchronous write port, one asynchronous read port, no reset.
module bfp_blk_buf #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bfp_normalize.sv
// Block-floating-point normalizer: buffers one block, tracks the minimum headroom,
// then streams the block back left-shifted by that common amount.
module bfp_normalize
    import bfp_pkg::*;
#(
    parameter  int WIDTH     = 16,
    parameter  int BLK_LEN   = 16,
    parameter  int MAX_SHIFT = WIDTH - 1,
    localparam int CNT_W     = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    input  logic [CNT_W-1:0] in_cnt_re,
    input  logic [CNT_W-1:0] in_cnt_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic [CNT_W-1:0] out_exp,
    output logic             out_last
);

    localparam int               IDX_W     = $clog2(BLK_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BLK_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] SHIFT_CAP = CNT_W'(MAX_SHIFT);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic [CNT_W-1:0]   min_cnt;
    logic [CNT_W-1:0]   min_next;
    logic [CNT_W-1:0]   shift_r;
    logic               in_fire;
    logic               out_fire;
    logic [2*WIDTH-1:0] rd_data;
    logic [WIDTH-1:0]   rd_re;
    logic [WIDTH-1:0]   rd_im;

    bfp_blk_buf #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (BLK_LEN)
    ) u_buf (
        .clk     (clk),
        .wr_en   (in_fire),
        .wr_addr (wr_idx),
        .wr_data ({in_re, in_im}),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    assign rd_re = rd_data[2*WIDTH-1:WIDTH];
    assign rd_im = rd_data[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        in_fire    = 1'b0;
        out_fire   = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                in_fire  = in_valid;
                if (in_valid && (wr_idx == LAST_IDX)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (rd_idx == LAST_IDX);
                out_fire  = out_ready;
                if (out_ready && (rd_idx == LAST_IDX)) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Running minimum including the sample being accepted this cycle.
    assign min_next = CNT_W'(min3(32'(min_cnt), 32'(in_cnt_re), 32'(in_cnt_im)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            min_cnt <= CNT_MAX;
            shift_r <= '0;
        end else begin
            if (in_fire) begin
                min_cnt <= min_next;
                if (wr_idx == LAST_IDX) begin
                    wr_idx  <= '0;
                    shift_r <= (min_next > SHIFT_CAP) ? SHIFT_CAP : min_next;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            if (out_fire) begin
                if (rd_idx == LAST_IDX) begin
                    rd_idx  <= '0;
                    min_cnt <= CNT_MAX;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end
        end
    end

    // shift_r never exceeds any component's headroom, so a plain left shift keeps the sign.
    assign out_re  = rd_re << shift_r;
    assign out_im  = rd_im << shift_r;
    assign out_exp = shift_r;

endmodule
